// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | imm_gen_pipe: registered RV immediate generator with output FIFO and   |
// | saturating illegal-opcode counter.                 Revision: 1.0       |
// +------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic [CNT_W-1:0] ill_count,
  input  logic             clr_count
);

  localparam int                c_ptr_w   = $clog2(DEPTH);
  localparam int                c_occ_w   = c_ptr_w + 1;
  localparam logic [c_occ_w-1:0] c_depth  = c_occ_w'(DEPTH);
  localparam logic [c_occ_w-1:0] c_occ_one = c_occ_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;
  localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);

  localparam logic [2:0] c_fmt_r   = 3'd0;
  localparam logic [2:0] c_fmt_i   = 3'd1;
  localparam logic [2:0] c_fmt_s   = 3'd2;
  localparam logic [2:0] c_fmt_b   = 3'd3;
  localparam logic [2:0] c_fmt_u   = 3'd4;
  localparam logic [2:0] c_fmt_j   = 3'd5;
  localparam logic [2:0] c_fmt_ill = 3'd7;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_sign;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  logic [XLEN-1:0]    r_imm_mem [DEPTH];
  logic [2:0]         r_fmt_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_occ_w-1:0] r_count;
  logic [XLEN-1:0]    r_imm_last;
  logic [2:0]         r_fmt_last;
  logic [CNT_W-1:0]   r_ill_count;

  assign w_sign = instruction[31];

  // Every RV immediate fits in 32 bits sign-extended; widen afterwards.
  always_comb begin
    w_imm32 = '0;
    w_fmt   = c_fmt_ill;
    case (instruction[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
        w_fmt   = c_fmt_i;
        w_imm32 = {{20{w_sign}}, instruction[31:20]};
      end
      7'b0100011: begin
        w_fmt   = c_fmt_s;
        w_imm32 = {{20{w_sign}}, instruction[31:25], instruction[11:7]};
      end
      7'b1100011: begin
        w_fmt   = c_fmt_b;
        w_imm32 = {{19{w_sign}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt   = c_fmt_u;
        w_imm32 = {instruction[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt   = c_fmt_j;
        w_imm32 = {{11{w_sign}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        w_fmt   = c_fmt_r;
        w_imm32 = '0;
      end
      default: begin
        w_fmt   = c_fmt_ill;
        w_imm32 = '0;
      end
    endcase
  end

  generate
    if (XLEN > 32) begin : g_sext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_nosext
      assign w_imm = w_imm32;
    end
  endgenerate

  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign in_ready  = !rst && !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = !w_empty && out_ready && !flush;

  // When empty the outputs show the most recently consumed entry.
  assign imm       = w_empty ? r_imm_last : r_imm_mem[r_rd_ptr];
  assign fmt       = w_empty ? r_fmt_last : r_fmt_mem[r_rd_ptr];
  assign ill_count = r_ill_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_imm_last <= '0;
      r_fmt_last <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_imm_mem[i] <= '0;
        r_fmt_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_imm_mem[r_wr_ptr] <= w_imm;
        r_fmt_mem[r_wr_ptr] <= w_fmt;
        r_wr_ptr            <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_imm_last <= r_imm_mem[r_rd_ptr];
        r_fmt_last <= r_fmt_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_occ_one;
        2'b01:   r_count <= r_count - c_occ_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ill_count <= '0;
    end else if (clr_count) begin
      r_ill_count <= '0;
    end else if (w_push && (w_fmt == c_fmt_ill) && (r_ill_count != c_cnt_max)) begin
      r_ill_count <= r_ill_count + c_cnt_one;
    end
  end

endmodule
`default_nettype wire
